score_digit_ctrl: RTL and testbench

//  Sequencer for the 5-digit on-screen number renderer. Captures a binary score and converts
//  it to BCD with a sequential double-dabble engine that runs only during vertical blanking.

---
 rtl/score_digit_ctrl.sv | 148 ++++++++++++++
 tb/tb_score_digit_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/score_digit_ctrl.sv
// Score sequencer for the 5-digit renderer: captures a score, converts it to BCD by double-dabble
// during vblank, and decodes col/row into digit slot + value. Optional macro: LEADING_ZERO_BLANK_EN.
module score_digit_ctrl #(
  parameter int SCORE_W    = 17,
  parameter int NUM_DIGITS = 5,
  parameter int COL_BEGIN  = 20,
  parameter int DIGIT_W    = 25,
  parameter int V_ACTIVE   = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         col,
  input  logic [9:0]         row,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic [2:0]         digit_sel,
  output logic [3:0]         num,
  output logic               digit_en,
  output logic               busy,
  output logic               overflow
);
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int CNT_W      = $clog2(SCORE_W + 1);
  localparam int SLOT_PITCH = DIGIT_W + 1;
  localparam int ROW_TOP    = 70;
  localparam int ROW_BOT    = 110;
  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(99999);

  typedef enum logic [2:0] {IDLE, WAIT, LOAD, SHIFT, COMMIT} state_t;
  state_t state, state_nxt;

  logic [SCORE_W-1:0] pending_reg, shift_reg;
  logic               pending;
  logic [BCD_W-1:0]   bcd, bcd_adj, display_reg;
  logic [CNT_W-1:0]   cnt;
  logic               vblank_start, last_shift;
  logic [2:0]         sel_nxt;
  logic [3:0]         num_nxt;
  logic               en_nxt;

  assign vblank_start = (row == 10'(V_ACTIVE)) && (col == 10'd0);
  assign last_shift   = (cnt == CNT_W'(SCORE_W - 1));
  assign busy         = (state == LOAD) || (state == SHIFT) || (state == COMMIT);

  // A strobe in the LOAD cycle wins over the clear, so that score is converted next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= 1'b0;
      pending_reg <= '0;
      overflow    <= 1'b0;
    end else if (score_valid) begin
      pending     <= 1'b1;
      pending_reg <= (score > MAX_SCORE) ? MAX_SCORE : score;
      overflow    <= (score > MAX_SCORE);
    end else if (state == LOAD) begin
      pending     <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending) state_nxt = WAIT;
      WAIT:    if (vblank_start) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Double-dabble correction: any nibble >= 5 would carry past 9 after the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg   <= '0;
      bcd         <= '0;
      cnt         <= '0;
      display_reg <= '0;
    end else begin
      case (state)
        LOAD: begin
          shift_reg <= pending_reg;
          bcd       <= '0;
          cnt       <= '0;
        end
        SHIFT: begin
          bcd       <= {bcd_adj[BCD_W-2:0], shift_reg[SCORE_W-1]};
          shift_reg <= shift_reg << 1;
          cnt       <= cnt + CNT_W'(1);
        end
        COMMIT:  display_reg <= bcd;
        default: ;
      endcase
    end
  end

  // Slot 1 is the most significant nibble; lead_zero tracks "all digits so far are zero".
  always_comb begin
    logic       in_band, lead_zero;
    logic [3:0] d;
    int         lo;
    sel_nxt   = '0;
    num_nxt   = '0;
    en_nxt    = 1'b0;
    lead_zero = 1'b1;
    d         = '0;
    lo        = 0;
    in_band   = (row >= 10'(ROW_TOP)) && (row < 10'(ROW_BOT));
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d         = display_reg[BCD_W-1-4*k -: 4];
      lead_zero = lead_zero && (d == 4'd0);
      lo        = COL_BEGIN + SLOT_PITCH * k;
      if (in_band && (int'(col) > lo) && (int'(col) <= lo + DIGIT_W)) begin
        sel_nxt = 3'(k + 1);
        num_nxt = d;
`ifdef LEADING_ZERO_BLANK_EN
        en_nxt  = !lead_zero || (k == NUM_DIGITS - 1);
`else
        en_nxt  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_sel <= '0;
      num       <= '0;
      digit_en  <= 1'b0;
    end else begin
      digit_sel <= sel_nxt;
      num       <= num_nxt;
      digit_en  <= en_nxt;
    end
  end

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Randomized bench for score_digit_ctrl against a frame-level model of the displayed number.
module tb_score_digit_ctrl;
  localparam int SCORE_W = 17;
  localparam int MAXV    = 99999;

  logic               clk = 1'b0, reset = 1'b0;
  logic [9:0]         col = '0, row = '0;
  logic [SCORE_W-1:0] score = '0;
  logic               score_valid = 1'b0;
  logic [2:0]         digit_sel;
  logic [3:0]         num;
  logic               digit_en, busy, overflow;

  score_digit_ctrl dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .score(score),
    .score_valid(score_valid), .digit_sel(digit_sel), .num(num),
    .digit_en(digit_en), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int m_disp = 0, m_pend = 0, m_pend_val = 0, m_ovf = 0;
  int pw [5] = '{10000, 1000, 100, 10, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slots repeat every 26 columns starting at col 21; the 26th column of each pitch is the gap.
  function automatic void exp_pix(input int c, input int r, output int sel, output int d,
                                  output int en);
    int k;
    sel = 0; d = 0; en = 0;
    if (r >= 70 && r < 110 && c >= 21) begin
      k = (c - 21) / 26 + 1;
      if ((c - 21) % 26 < 25 && k <= 5) begin
        sel = k;
        d   = (m_disp / pw[k-1]) % 10;
`ifdef LEADING_ZERO_BLANK_EN
        en  = (k == 5 || m_disp >= pw[k-1]) ? 1 : 0;
`else
        en  = 1;
`endif
      end
    end
  endfunction

  // sc < 0 means no strobe this cycle
  task automatic step(input int c, input int r, input int sc);
    int es, ed, ee;
    col = 10'(c);
    row = 10'(r);
    score_valid = (sc >= 0);
    score = (sc >= 0) ? SCORE_W'(sc) : '0;
    exp_pix(c, r, es, ed, ee);
    @(posedge clk); #1;
    score_valid = 1'b0;
    if (sc >= 0) begin
      m_pend     = 1;
      m_pend_val = (sc > MAXV) ? MAXV : sc;
      m_ovf      = (sc > MAXV) ? 1 : 0;
    end
    chk("sel", digit_sel, es);
    chk("num", num, ed);
    chk("en", digit_en, ee);
  endtask

  // Active scan with up to two strobes, then vblank with an optional strobe mid-conversion.
  task automatic frame(input int s1, input int s2, input int sw);
    int sweep [14] = '{20, 21, 45, 46, 47, 33, 59, 85, 111, 137, 124, 125, 149, 150};
    int conv, cval;
    foreach (sweep[i]) step(sweep[i], 75, -1);
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 170), $urandom_range(65, 115), (i == 10) ? s1 : (i == 60) ? s2 : -1);
    repeat (3) step(799, 479, -1);
    conv = m_pend;
    cval = m_pend_val;
    m_pend = 0;
    step(0, 480, -1);
    chk("busy_vb", busy, conv);
    for (int i = 1; i < 30; i++) begin
      step($urandom_range(1, 799), 481, (i == 6) ? sw : -1);
      chk("busy_win", busy, (conv != 0 && i <= 18) ? 1 : 0);
    end
    if (conv != 0) m_disp = cval;
    chk("ovf", overflow, m_ovf);
  endtask

  function automatic int rnd_score();
    case ($urandom % 6)
      0, 1:    return -1;
      2:       return int'($urandom % 100000);
      3:       return int'($urandom_range(100000, 131071));
      4:       return int'($urandom % 100);
      default: return 0;
    endcase
  endfunction

  initial begin
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", digit_sel, 0);
    chk("rst_num", num, 0);
    chk("rst_en", digit_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;

    frame(-1, -1, -1);
    frame(12345, -1, -1);
    frame(123456, -1, -1);
    frame(7, -1, -1);
    frame(500, 600, 700);
    frame(-1, -1, -1);
    for (int f = 0; f < 8; f++) frame(rnd_score(), rnd_score(), rnd_score());

    // Reset in the middle of a conversion discards it and clears the display.
    frame(86420, -1, -1);
    step(100, 100, 54321);
    repeat (5) step(799, 479, -1);
    step(0, 480, -1);
    for (int i = 1; i <= 8; i++) step(500, 481, -1);
    chk("mid_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_sel", digit_sel, 0);
    chk("mid_ovf", overflow, 0);
    m_disp = 0; m_pend = 0; m_ovf = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (25) begin
      step(500, 481, -1);
      chk("mid_busy_after", busy, 0);
    end
    frame(-1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
